// File: rtl/fitness_evaluator_if.sv
// Connection bundle between the fitness evaluator, the evolved circuit under test,
// and the truth-table that holds the expected responses.
interface fitness_evaluator_if #(
    parameter int NUM_IN  = 5,
    parameter int NUM_OUT = 4,
    parameter int SCORE_W = 8
);
    logic               start;
    logic [NUM_IN-1:0]  dut_in;
    logic [NUM_OUT-1:0] dut_out;
    logic [NUM_IN-1:0]  target_addr;
    logic [NUM_OUT-1:0] target_data;
    logic               busy;
    logic               done;
    logic [SCORE_W-1:0] score;
    logic               perfect;

    modport master (
        input  start,
        input  dut_out,
        input  target_data,
        output dut_in,
        output target_addr,
        output busy,
        output done,
        output score,
        output perfect
    );

    modport slave (
        output start,
        output dut_out,
        output target_data,
        input  dut_in,
        input  target_addr,
        input  busy,
        input  done,
        input  score,
        input  perfect
    );
endinterface

// File: rtl/fitness_evaluator.sv
// Sweeps every input vector through an evolved circuit and counts the output bits
// that agree with a reference truth table.
module fitness_evaluator #(
    parameter int NUM_IN        = 5,
    parameter int NUM_OUT       = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int SCORE_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    fitness_evaluator_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        COMPARE,
        DONE
    } state_t;

    localparam logic [NUM_IN-1:0]  LAST_IDX    = {NUM_IN{1'b1}};
    localparam logic [3:0]         SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] MAX_SCORE   = SCORE_W'((2 ** NUM_IN) * NUM_OUT);

    state_t             state_reg;
    logic [NUM_IN-1:0]  idx_reg;
    logic [3:0]         settle_cnt_reg;
    logic [SCORE_W-1:0] score_reg;
    logic               busy_reg;
    logic               done_reg;

    logic [NUM_OUT-1:0] match_bits;
    logic [SCORE_W-1:0] match_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_match
            assign match_bits[gi] = ~(bus.dut_out[gi] ^ bus.target_data[gi]);
        end
    endgenerate

    always_comb begin
        match_cnt = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            match_cnt = match_cnt + SCORE_W'(match_bits[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            settle_cnt_reg <= '0;
            score_reg      <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        score_reg <= '0;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= APPLY;
                    end
                end
                APPLY: begin
                    settle_cnt_reg <= SETTLE_LOAD;
                    state_reg      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt_reg == 4'd0) begin
                        state_reg <= COMPARE;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - 4'd1;
                    end
                end
                COMPARE: begin
                    score_reg <= score_reg + match_cnt;
                    if (idx_reg == LAST_IDX) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        idx_reg   <= idx_reg + 1'b1;
                        state_reg <= APPLY;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // The vector index doubles as the stimulus, so it holds the last vector while idle.
    assign bus.dut_in      = idx_reg;
    assign bus.target_addr = idx_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.score       = score_reg;
    assign bus.perfect     = (score_reg == MAX_SCORE);

endmodule
